// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the data memory.
// Range-checks each request, holds one strobe for MEM_LAT cycles, returns one response.
module dmem_arbiter #(
    parameter logic [31:0] ADDR_LO = 32'd250,
    parameter logic [31:0] ADDR_HI = 32'd2499,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_t      state;
    state_t      state_nx;
    req_t        cur;
    req_t        sel;
    logic        last;
    logic [2:0]  cnt;
    logic        any_req;
    logic        win;
    logic        legal;
    logic        go_resp;
    logic        resp_id;
    logic        resp_err;
    logic [31:0] resp_data;

    // last == 1 means port 1 was granted most recently
    always_comb begin
        any_req   = m0_req || m1_req;
        win       = (m0_req && m1_req) ? ~last : m1_req;
        sel.id    = win;
        sel.we    = win ? m1_we    : m0_we;
        sel.addr  = win ? m1_addr  : m0_addr;
        sel.wdata = win ? m1_wdata : m0_wdata;
        legal     = (sel.addr >= ADDR_LO) && (sel.addr <= ADDR_HI);
    end

    always_comb begin
        state_nx  = state;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    m0_gnt   = ~win;
                    m1_gnt   = win;
                    state_nx = legal ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                mem_read  = ~cur.we;
                mem_write = cur.we;
                if (cnt == 3'd0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign mem_addr  = cur.addr;
    assign mem_wdata = cur.wdata;

    // A range fault reaches RESP straight from IDLE, before cur is loaded
    always_comb begin
        go_resp   = (state_nx == RESP);
        resp_id   = (state == IDLE) ? win : cur.id;
        resp_err  = (state == IDLE);
        resp_data = '0;
        if (state == ACCESS && !cur.we) begin
            resp_data = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur       <= '0;
            last      <= 1'b1;
            cnt       <= 3'd0;
            m0_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                cur  <= sel;
                last <= win;
                cnt  <= LAT_LAST;
            end else if (state == ACCESS && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            m0_rvalid <= go_resp && !resp_id;
            m0_err    <= go_resp && !resp_id && resp_err;
            m0_rdata  <= (go_resp && !resp_id) ? resp_data : '0;
            m1_rvalid <= go_resp && resp_id;
            m1_err    <= go_resp && resp_id && resp_err;
            m1_rdata  <= (go_resp && resp_id) ? resp_data : '0;
        end
    end

endmodule
